// File: rtl/bp_be_store_buffer_if.sv
// ============================================================================
// Module   : bp_be_store_buffer_if
// Purpose  : Enqueue / commit / drain / forward bundle for the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_be_store_buffer_if #(
    parameter int els_p         = 4,
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64
);
    localparam int offset_lp = $clog2(dword_width_p/8);
    localparam int ptr_lp    = $clog2(els_p);
    localparam int addr_lp   = paddr_width_p - offset_lp;
    localparam int mask_lp   = dword_width_p/8;

    logic                     enq_v_i;
    logic                     enq_ready_o;
    logic [addr_lp-1:0]       enq_paddr_i;
    logic [dword_width_p-1:0] enq_data_i;
    logic [mask_lp-1:0]       enq_mask_i;
    logic                     commit_v_i;
    logic                     flush_i;
    logic                     drain_v_o;
    logic [addr_lp-1:0]       drain_paddr_o;
    logic [dword_width_p-1:0] drain_data_o;
    logic [mask_lp-1:0]       drain_mask_o;
    logic                     drain_yumi_i;
    logic                     fwd_v_i;
    logic [addr_lp-1:0]       fwd_paddr_i;
    logic [mask_lp-1:0]       fwd_mask_i;
    logic                     fwd_v_o;
    logic [dword_width_p-1:0] fwd_data_o;
    logic [mask_lp-1:0]       fwd_mask_o;
    logic                     fwd_full_o;
    logic [ptr_lp:0]          count_o;
    logic                     empty_o;
    logic                     full_o;

    modport master (
        output enq_v_i, enq_paddr_i, enq_data_i, enq_mask_i, commit_v_i, flush_i,
               drain_yumi_i, fwd_v_i, fwd_paddr_i, fwd_mask_i,
        input  enq_ready_o, drain_v_o, drain_paddr_o, drain_data_o, drain_mask_o,
               fwd_v_o, fwd_data_o, fwd_mask_o, fwd_full_o, count_o, empty_o, full_o
    );

    modport slave (
        input  enq_v_i, enq_paddr_i, enq_data_i, enq_mask_i, commit_v_i, flush_i,
               drain_yumi_i, fwd_v_i, fwd_paddr_i, fwd_mask_i,
        output enq_ready_o, drain_v_o, drain_paddr_o, drain_data_o, drain_mask_o,
               fwd_v_o, fwd_data_o, fwd_mask_o, fwd_full_o, count_o, empty_o, full_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_be_store_buffer.sv
// ============================================================================
// Module   : bp_be_store_buffer
// Purpose  : Commit-ordered store buffer with registered byte-wise forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_store_buffer #(
    parameter int els_p         = 4,
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_be_store_buffer_if.slave    bus
);
    localparam int offset_lp = $clog2(dword_width_p/8);
    localparam int ptr_lp    = $clog2(els_p);
    localparam int addr_lp   = paddr_width_p - offset_lp;
    localparam int mask_lp   = dword_width_p/8;

    logic [ptr_lp:0]          r_head, r_cptr, r_tail;
    logic [ptr_lp:0]          w_head_n, w_cptr_n, w_tail_n, w_occ, w_count_n;
    logic [ptr_lp:0]          r_count;
    logic                     r_empty, r_full;
    logic [addr_lp-1:0]       r_addr_mem [els_p];
    logic [dword_width_p-1:0] r_data_mem [els_p];
    logic [mask_lp-1:0]       r_mask_mem [els_p];
    logic                     w_enq_fire, w_commit, w_drain_v, w_drain;
    logic [dword_width_p-1:0] w_fwd_data;
    logic [mask_lp-1:0]       w_fwd_hit;
    logic                     r_fwd_v, r_fwd_full;
    logic [dword_width_p-1:0] r_fwd_data;
    logic [mask_lp-1:0]       r_fwd_mask;

    // Space is judged on registered state only: a same-cycle drain never frees a slot.
    assign w_enq_fire = bus.enq_v_i & ~r_full & ~bus.flush_i;
    assign w_commit   = bus.commit_v_i & (r_cptr != r_tail);
    assign w_drain_v  = (r_head != r_cptr);
    assign w_drain    = bus.drain_yumi_i & w_drain_v;
    assign w_occ      = r_tail - r_head;

    assign w_head_n  = r_head + (ptr_lp+1)'(w_drain);
    assign w_cptr_n  = r_cptr + (ptr_lp+1)'(w_commit);
    assign w_tail_n  = bus.flush_i ? w_cptr_n : r_tail + (ptr_lp+1)'(w_enq_fire);
    assign w_count_n = w_tail_n - w_head_n;

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    always_comb begin
        w_fwd_data = '0;
        w_fwd_hit  = '0;
        for (int i = 0; i < els_p; i++) begin
            logic [ptr_lp-1:0] idx;
            idx = r_head[ptr_lp-1:0] + ptr_lp'(i);
            if (((ptr_lp+1)'(i) < w_occ) && (r_addr_mem[idx] == bus.fwd_paddr_i)) begin
                for (int b = 0; b < mask_lp; b++) begin
                    if (r_mask_mem[idx][b] & bus.fwd_mask_i[b]) begin
                        w_fwd_hit[b]        = 1'b1;
                        w_fwd_data[8*b +: 8] = r_data_mem[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_head     <= '0;
            r_cptr     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_fwd_v    <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_mask <= '0;
            r_fwd_full <= 1'b0;
        end else begin
            r_head  <= w_head_n;
            r_cptr  <= w_cptr_n;
            r_tail  <= w_tail_n;
            r_count <= w_count_n;
            r_empty <= (w_count_n == '0);
            r_full  <= (w_count_n == (ptr_lp+1)'(els_p));
            r_fwd_v <= bus.fwd_v_i;
            if (bus.fwd_v_i) begin
                r_fwd_data <= w_fwd_data;
                r_fwd_mask <= w_fwd_hit;
                r_fwd_full <= (w_fwd_hit == bus.fwd_mask_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq_fire) begin
            r_addr_mem[r_tail[ptr_lp-1:0]] <= bus.enq_paddr_i;
            r_data_mem[r_tail[ptr_lp-1:0]] <= bus.enq_data_i;
            r_mask_mem[r_tail[ptr_lp-1:0]] <= bus.enq_mask_i;
        end
    end

    assign bus.enq_ready_o   = ~r_full;
    assign bus.drain_v_o     = w_drain_v;
    assign bus.drain_paddr_o = r_addr_mem[r_head[ptr_lp-1:0]];
    assign bus.drain_data_o  = r_data_mem[r_head[ptr_lp-1:0]];
    assign bus.drain_mask_o  = r_mask_mem[r_head[ptr_lp-1:0]];
    assign bus.fwd_v_o       = r_fwd_v;
    assign bus.fwd_data_o    = r_fwd_data;
    assign bus.fwd_mask_o    = r_fwd_mask;
    assign bus.fwd_full_o    = r_fwd_full;
    assign bus.count_o       = r_count;
    assign bus.empty_o       = r_empty;
    assign bus.full_o        = r_full;

    a_commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.commit_v_i |-> (r_cptr != r_tail));
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.drain_yumi_i |-> w_drain_v);

endmodule

`default_nettype wire

// File: tb/tb_bp_be_store_buffer.sv
// ============================================================================
// Module   : tb_bp_be_store_buffer
// Purpose  : Scenario and randomized checks against a queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_be_store_buffer;
    localparam int ELS = 4;
    localparam int PA  = 40;
    localparam int DW  = 64;
    localparam int MW  = DW/8;
    localparam int AW  = PA - 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bp_be_store_buffer_if #(.els_p(ELS), .paddr_width_p(PA), .dword_width_p(DW)) bus ();
    bp_be_store_buffer #(.els_p(ELS), .paddr_width_p(PA), .dword_width_p(DW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
    );

    // Reference model: program-ordered queue, first ncom entries are committed.
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    logic [MW-1:0] q_mask[$];
    int ncom = 0;
    int n_enq = 0;
    int n_drain = 0;
    logic          exp_fwd_v = 1'b0;
    logic [DW-1:0] exp_fwd_data = '0;
    logic [MW-1:0] exp_fwd_mask = '0;
    logic          exp_fwd_full = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic clear_inputs();
        bus.enq_v_i = 0; bus.enq_paddr_i = '0; bus.enq_data_i = '0; bus.enq_mask_i = '0;
        bus.commit_v_i = 0; bus.flush_i = 0; bus.drain_yumi_i = 0;
        bus.fwd_v_i = 0; bus.fwd_paddr_i = '0; bus.fwd_mask_i = '0;
    endtask

    task automatic model_reset();
        q_addr.delete(); q_data.delete(); q_mask.delete();
        ncom = 0;
        exp_fwd_v = 0; exp_fwd_data = '0; exp_fwd_mask = '0; exp_fwd_full = 0;
    endtask

    // Advance one edge, update the model from pre-edge state, leave at posedge+1.
    task automatic cycle();
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        bit enq_ok, commit_ok, drain_ok;
        @(posedge clk);
        exp_fwd_v = bus.fwd_v_i;
        if (bus.fwd_v_i) begin
            d = '0; m = '0;
            for (int e = 0; e < q_addr.size(); e++)
                if (q_addr[e] == bus.fwd_paddr_i)
                    for (int b = 0; b < MW; b++)
                        if (q_mask[e][b] && bus.fwd_mask_i[b]) begin
                            m[b] = 1'b1;
                            d[8*b +: 8] = q_data[e][8*b +: 8];
                        end
            exp_fwd_data = d; exp_fwd_mask = m; exp_fwd_full = (m == bus.fwd_mask_i);
        end
        enq_ok    = bus.enq_v_i && (q_addr.size() < ELS) && !bus.flush_i;
        commit_ok = bus.commit_v_i && (ncom < q_addr.size());
        drain_ok  = bus.drain_yumi_i && (ncom > 0);
        if (commit_ok) ncom++;
        if (drain_ok) begin
            void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_mask.pop_front());
            ncom--; n_drain++;
        end
        if (bus.flush_i)
            while (q_addr.size() > ncom) begin
                void'(q_addr.pop_back()); void'(q_data.pop_back()); void'(q_mask.pop_back());
            end
        if (enq_ok) begin
            q_addr.push_back(bus.enq_paddr_i); q_data.push_back(bus.enq_data_i);
            q_mask.push_back(bus.enq_mask_i); n_enq++;
        end
        #1;
        clear_inputs();
    endtask

    // Commits everything resident, then drains it all.
    task automatic retire_all();
        while (ncom < q_addr.size()) begin bus.commit_v_i = 1; cycle(); end
        while (ncom > 0) begin bus.drain_yumi_i = 1; cycle(); end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++; if (bus.count_o !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty_o); end
        checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full_o); end
        checks++; if (bus.enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.enq_ready_o); end
        checks++; if (bus.drain_v_o !== 1'b0) begin errors++; $display("FAIL reset_drain_v got %b want 0", bus.drain_v_o); end
        checks++; if (bus.fwd_v_o !== 1'b0 || bus.fwd_mask_o !== '0 || bus.fwd_data_o !== '0 || bus.fwd_full_o !== 1'b0) begin
            errors++; $display("FAIL reset_fwd got v=%b m=%h d=%h f=%b want all 0",
                               bus.fwd_v_o, bus.fwd_mask_o, bus.fwd_data_o, bus.fwd_full_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < ELS; i++) begin
            bus.enq_v_i = 1; bus.enq_paddr_i = AW'(32 + i);
            bus.enq_data_i = {$urandom(), $urandom()}; bus.enq_mask_i = MW'($urandom());
            cycle();
        end
        checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.full_o); end
        checks++; if (bus.enq_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", bus.enq_ready_o); end
        checks++; if (bus.count_o !== 3'(ELS)) begin errors++; $display("FAIL fill_count got %0d want %0d", bus.count_o, ELS); end
        // Fifth store plus a drain in the same cycle: neither frees space for it.
        bus.commit_v_i = 1; cycle();
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'(99); bus.drain_yumi_i = 1; cycle();
        checks++; if (bus.count_o !== 3'(q_addr.size()) || q_addr.size() != ELS - 1) begin
            errors++; $display("FAIL fill_reject got count %0d want %0d", bus.count_o, ELS - 1);
        end
        retire_all();
    endtask

    task automatic test_drain_hold();
        logic [DW-1:0] d;
        d = {$urandom(), $urandom()};
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h10); bus.enq_data_i = d; bus.enq_mask_i = 8'h0F;
        cycle();
        checks++; if (bus.drain_v_o !== 1'b0) begin errors++; $display("FAIL hold_early_drain got %b want 0", bus.drain_v_o); end
        bus.commit_v_i = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.drain_v_o !== 1'b1 || bus.drain_paddr_o !== AW'('h10) ||
                          bus.drain_data_o !== d || bus.drain_mask_o !== 8'h0F) begin
                errors++; $display("FAIL hold_payload got v=%b a=%h d=%h m=%h want 1 10 %h 0f",
                                   bus.drain_v_o, bus.drain_paddr_o, bus.drain_data_o, bus.drain_mask_o, d);
            end
            cycle();
        end
        bus.drain_yumi_i = 1; cycle();
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL hold_empty got %b want 1", bus.empty_o); end
    endtask

    task automatic test_flush();
        logic [AW-1:0] a0;
        a0 = AW'($urandom_range(1, 1000));
        for (int i = 0; i < 3; i++) begin
            bus.enq_v_i = 1; bus.enq_paddr_i = a0 + AW'(i);
            bus.enq_data_i = {$urandom(), $urandom()}; bus.enq_mask_i = 8'hFF;
            cycle();
        end
        bus.commit_v_i = 1; cycle();
        bus.flush_i = 1; bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h7777); bus.enq_mask_i = 8'hFF;
        cycle();
        checks++; if (bus.count_o !== 1) begin errors++; $display("FAIL flush_count got %0d want 1", bus.count_o); end
        checks++; if (bus.drain_v_o !== 1'b1 || bus.drain_paddr_o !== a0) begin
            errors++; $display("FAIL flush_drain got v=%b a=%h want 1 %h", bus.drain_v_o, bus.drain_paddr_o, a0);
        end
        bus.drain_yumi_i = 1; cycle();
        checks++; if (bus.empty_o !== 1'b1 || bus.drain_v_o !== 1'b0) begin
            errors++; $display("FAIL flush_empty got e=%b v=%b want 1 0", bus.empty_o, bus.drain_v_o);
        end
    endtask

    task automatic test_forward();
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h40); bus.enq_data_i = 64'h1122334455667788; bus.enq_mask_i = 8'hFF;
        cycle();
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h40); bus.enq_data_i = 64'h00000000000000AA; bus.enq_mask_i = 8'h01;
        cycle();
        bus.fwd_v_i = 1; bus.fwd_paddr_i = AW'('h40); bus.fwd_mask_i = 8'hFF;
        cycle();
        checks++; if (bus.fwd_v_o !== 1'b1 || bus.fwd_data_o !== 64'h11223344556677AA ||
                      bus.fwd_mask_o !== 8'hFF || bus.fwd_full_o !== 1'b1) begin
            errors++; $display("FAIL fwd_merge got v=%b d=%h m=%h f=%b want 1 11223344556677aa ff 1",
                               bus.fwd_v_o, bus.fwd_data_o, bus.fwd_mask_o, bus.fwd_full_o);
        end
        bus.fwd_v_i = 1; bus.fwd_paddr_i = AW'('h41); bus.fwd_mask_i = 8'hFF;
        cycle();
        checks++; if (bus.fwd_v_o !== 1'b1 || bus.fwd_mask_o !== 8'h00 || bus.fwd_full_o !== 1'b0 || bus.fwd_data_o !== '0) begin
            errors++; $display("FAIL fwd_miss got v=%b m=%h f=%b d=%h want 1 00 0 0",
                               bus.fwd_v_o, bus.fwd_mask_o, bus.fwd_full_o, bus.fwd_data_o);
        end
        // Same-cycle enqueue is invisible; same-cycle flushed entries still forward.
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h50); bus.enq_data_i = '1; bus.enq_mask_i = 8'hFF;
        bus.fwd_v_i = 1; bus.fwd_paddr_i = AW'('h50); bus.fwd_mask_i = 8'h0F;
        cycle();
        checks++; if (bus.fwd_mask_o !== 8'h00) begin errors++; $display("FAIL fwd_same_cycle got %h want 00", bus.fwd_mask_o); end
        bus.flush_i = 1; bus.fwd_v_i = 1; bus.fwd_paddr_i = AW'('h40); bus.fwd_mask_i = 8'h03;
        cycle();
        checks++; if (bus.fwd_mask_o !== 8'h03 || bus.fwd_data_o !== 64'h77AA || bus.fwd_full_o !== 1'b1) begin
            errors++; $display("FAIL fwd_flush_cycle got m=%h d=%h f=%b want 03 77aa 1",
                               bus.fwd_mask_o, bus.fwd_data_o, bus.fwd_full_o);
        end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL fwd_flush_empty got %b want 1", bus.empty_o); end
    endtask

    task automatic test_random();
        int start_drain, start_enq;
        start_drain = n_drain; start_enq = n_enq;
        for (int cyc = 0; cyc < 3000 && (n_drain - start_drain) < 20; cyc++) begin
            if ((n_enq - start_enq) < 20 && $urandom_range(0, 2) != 0) begin
                bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h100 + $urandom_range(0, 3));
                bus.enq_data_i = {$urandom(), $urandom()}; bus.enq_mask_i = MW'($urandom());
            end
            if (ncom < q_addr.size() && $urandom_range(0, 1) == 1) bus.commit_v_i = 1;
            if (ncom > 0 && $urandom_range(0, 2) != 0) bus.drain_yumi_i = 1;
            if ($urandom_range(0, 1) == 1) begin
                bus.fwd_v_i = 1; bus.fwd_paddr_i = AW'('h100 + $urandom_range(0, 3));
                bus.fwd_mask_i = MW'($urandom());
            end
            cycle();
            checks++; if (bus.count_o !== 3'(q_addr.size()) || bus.count_o > 3'(ELS)) begin
                errors++; $display("FAIL rnd_count got %0d want %0d", bus.count_o, q_addr.size());
            end
            checks++; if (bus.enq_ready_o !== (q_addr.size() < ELS) || bus.drain_v_o !== (ncom > 0)) begin
                errors++; $display("FAIL rnd_flags got rdy=%b dv=%b want %b %b",
                                   bus.enq_ready_o, bus.drain_v_o, q_addr.size() < ELS, ncom > 0);
            end
            if (ncom > 0) begin
                checks++; if (bus.drain_paddr_o !== q_addr[0] || bus.drain_data_o !== q_data[0] || bus.drain_mask_o !== q_mask[0]) begin
                    errors++; $display("FAIL rnd_drain_order got a=%h d=%h m=%h want %h %h %h",
                                       bus.drain_paddr_o, bus.drain_data_o, bus.drain_mask_o, q_addr[0], q_data[0], q_mask[0]);
                end
            end
            checks++; if (bus.fwd_v_o !== exp_fwd_v || bus.fwd_data_o !== exp_fwd_data ||
                          bus.fwd_mask_o !== exp_fwd_mask || bus.fwd_full_o !== exp_fwd_full) begin
                errors++; $display("FAIL rnd_fwd got v=%b d=%h m=%h f=%b want %b %h %h %b",
                                   bus.fwd_v_o, bus.fwd_data_o, bus.fwd_mask_o, bus.fwd_full_o,
                                   exp_fwd_v, exp_fwd_data, exp_fwd_mask, exp_fwd_full);
            end
        end
        checks++; if ((n_drain - start_drain) < 20) begin
            errors++; $display("FAIL rnd_budget got %0d drains want 20", n_drain - start_drain);
        end
        // Leave committed and uncommitted entries plus a live forward result, then reset.
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h200); bus.enq_data_i = '1; bus.enq_mask_i = 8'hFF; cycle();
        bus.enq_v_i = 1; bus.enq_paddr_i = AW'('h201); bus.enq_mask_i = 8'hFF; bus.commit_v_i = 1;
        bus.fwd_v_i = 1; bus.fwd_paddr_i = AW'('h200); bus.fwd_mask_i = 8'hFF; cycle();
        #3;
        reset_n = 0;
        #1;
        checks++; if (bus.count_o !== 0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 || bus.enq_ready_o !== 1'b1) begin
            errors++; $display("FAIL midreset_state got c=%0d e=%b f=%b r=%b want 0 1 0 1",
                               bus.count_o, bus.empty_o, bus.full_o, bus.enq_ready_o);
        end
        checks++; if (bus.drain_v_o !== 1'b0 || bus.fwd_v_o !== 1'b0 || bus.fwd_mask_o !== '0 ||
                      bus.fwd_data_o !== '0 || bus.fwd_full_o !== 1'b0) begin
            errors++; $display("FAIL midreset_out got dv=%b fv=%b m=%h d=%h f=%b want all 0",
                               bus.drain_v_o, bus.fwd_v_o, bus.fwd_mask_o, bus.fwd_data_o, bus.fwd_full_o);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain_hold();
        test_flush();
        test_forward();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
